// File: rtl/apb_master_bridge_if.sv
// Command stream, response stream and APB bus of the APB master bridge.
// The master modport is the bridge side; the slave modport is the host/APB-slave side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, pready, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, pready, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into single APB transfers and returns
// read data / timeout status on a valid/ready response channel.
module apb_master_bridge #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  apb_master_bridge_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.req_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_timeout <= 1'b0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.paddr       <= '0;
      bus.pwrite      <= 1'b0;
      bus.pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            bus.psel      <= 1'b1;
            bus.penable   <= 1'b0;
            bus.paddr     <= bus.req_addr;
            bus.pwrite    <= bus.req_write;
            bus.pwdata    <= bus.req_write ? bus.req_wdata : '0;
            state         <= SETUP;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over an expiring wait counter
          if (bus.pready) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (TIMEOUT != 0 && cnt == LAST) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.req_ready   <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: APB slave model with programmable wait states plus a
// transaction-level memory model predicting every response.
module tb_apb_master_bridge;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected memory contents seen through the bridge
  logic [31:0] rmem [int];
  // slave-side storage
  logic [31:0] smem [int];
  int s_waits = 0, s_seen = 0, acc_cycles = 0;
  bit s_stuck = 1'b0;

  function automatic logic [31:0] dflt(input logic [9:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // APB slave: s_waits low-pready ACCESS cycles, then completes (never if stuck)
  initial begin
    bif.pready = 1'b0;
    bif.prdata = '0;
    forever begin
      @(negedge clk);
      if (bif.psel && bif.penable) begin
        acc_cycles++;
        if (!s_stuck && s_seen >= s_waits) begin
          bif.pready = 1'b1;
          if (bif.pwrite) begin
            smem[int'(bif.paddr)] = bif.pwdata;
            bif.prdata = $urandom;
          end else begin
            bif.prdata = smem.exists(int'(bif.paddr)) ? smem[int'(bif.paddr)] : dflt(bif.paddr);
          end
        end else begin
          bif.pready = 1'b0;
          bif.prdata = $urandom;
          s_seen++;
        end
      end else begin
        bif.pready = 1'($urandom_range(0, 1));
        bif.prdata = $urandom;
        s_seen = 0;
      end
    end
  end

  // bus protocol monitor
  initial begin
    logic pp_sel, pp_en;
    logic [9:0] pp_addr;
    pp_sel = 1'b0; pp_en = 1'b0; pp_addr = '0;
    forever begin
      @(negedge clk);
      if (bif.penable) begin
        tests++;
        if (!bif.psel) begin
          errs++;
          $display("FAIL penable_implies_psel: psel=%0b required 1", bif.psel);
        end
        if (!pp_en && !(pp_sel && pp_addr == bif.paddr)) begin
          errs++;
          $display("FAIL setup_before_access: prev psel=%0b addr=%h, now addr=%h", pp_sel, pp_addr, bif.paddr);
        end
        if (pp_en && pp_addr != bif.paddr) begin
          errs++;
          $display("FAIL paddr_stable: %h required %h", bif.paddr, pp_addr);
        end
      end
      pp_sel = bif.psel; pp_en = bif.penable; pp_addr = bif.paddr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one command; called just after a negedge. Latency counts cycles from
  // the accept cycle to the first cycle with rsp_valid high.
  task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] d,
                      input int waits, input bit stuck, input int rdelay,
                      output logic [31:0] o_rdata, output bit o_to, output int o_lat,
                      output int o_acc, output bit o_setup_ok, output bit o_bp_ok,
                      output int o_acc_cyc);
    int n;
    s_waits = waits; s_stuck = stuck; acc_cycles = 0;
    bif.rsp_ready = (rdelay == 0);
    bif.req_valid = 1'b1; bif.req_write = wr; bif.req_addr = a; bif.req_wdata = d;
    n = 0;
    while (!bif.req_ready && n < 50) begin @(negedge clk); n++; end
    o_acc_cyc = cyc;
    @(negedge clk);
    o_lat = 1;
    bif.req_valid = 1'b0;
    bif.req_write = 1'($urandom); bif.req_addr = 10'($urandom); bif.req_wdata = $urandom;
    o_setup_ok = bif.psel && !bif.penable && bif.paddr == a && bif.pwrite == wr &&
                 bif.pwdata == (wr ? d : 32'h0);
    while (!bif.rsp_valid && o_lat < 100) begin @(negedge clk); o_lat++; end
    o_rdata = bif.rsp_rdata; o_to = bif.rsp_timeout; o_acc = acc_cycles;
    o_bp_ok = 1'b1;
    if (rdelay > 0) begin
      // a competing command must not be taken while the response is pending
      bif.req_valid = 1'b1; bif.req_write = 1'b1;
      repeat (rdelay) begin
        @(negedge clk);
        if (!bif.rsp_valid || bif.rsp_rdata !== o_rdata || bif.rsp_timeout !== o_to ||
            bif.req_ready || bif.psel) o_bp_ok = 1'b0;
      end
      bif.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bif.req_valid = 1'b0;
    if (bif.rsp_valid || bif.psel || !bif.req_ready) o_bp_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bif.req_ready, bif.rsp_valid, bif.rsp_timeout, bif.psel, bif.penable, bif.pwrite} !== 6'b0 ||
        bif.rsp_rdata !== 32'h0 || bif.paddr !== 10'h0 || bif.pwdata !== 32'h0) begin
      errs++;
      $display("FAIL reset_values: rdy=%b vld=%b to=%b sel=%b en=%b wr=%b rd=%h ad=%h wd=%h required all 0",
               bif.req_ready, bif.rsp_valid, bif.rsp_timeout, bif.psel, bif.penable, bif.pwrite,
               bif.rsp_rdata, bif.paddr, bif.pwdata);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bif.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL req_ready_after_reset: %b required 1", bif.req_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    logic [31:0] rd; bit to, su, bp; int lat, acc, ac;
    xfer(1'b1, 10'h3A4, 32'hDEADBEEF, 0, 1'b0, 0, rd, to, lat, acc, su, bp, ac);
    rmem[10'h3A4] = 32'hDEADBEEF;
    tests++;
    if (lat !== 3 || acc !== 1) begin
      errs++;
      $display("FAIL write_latency: lat=%0d acc=%0d required 3/1", lat, acc);
    end
    tests++;
    if (rd !== 32'h0 || to !== 1'b0 || !su) begin
      errs++;
      $display("FAIL write_response: rdata=%h to=%b setup_ok=%b required 0/0/1", rd, to, su);
    end
  endtask

  task automatic test_read_waits();
    logic [31:0] rd; bit to, su, bp; int lat, acc, ac;
    smem[16] = 32'h12345678;
    rmem[16] = 32'h12345678;
    xfer(1'b0, 10'h010, 32'hFFFF_FFFF, 3, 1'b0, 0, rd, to, lat, acc, su, bp, ac);
    tests++;
    if (acc !== 4 || lat !== 6) begin
      errs++;
      $display("FAIL read_wait_penable: acc=%0d lat=%0d required 4/6", acc, lat);
    end
    tests++;
    if (rd !== 32'h12345678 || to !== 1'b0 || !su) begin
      errs++;
      $display("FAIL read_wait_data: rdata=%h to=%b setup_ok=%b required 12345678/0/1", rd, to, su);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; bit to, su, bp; int lat, acc, ac;
    xfer(1'b0, 10'h2FF, 32'h0, 0, 1'b1, 0, rd, to, lat, acc, su, bp, ac);
    tests++;
    if (acc !== TIMEOUT || lat !== TIMEOUT + 2) begin
      errs++;
      $display("FAIL timeout_cycles: acc=%0d lat=%0d required %0d/%0d", acc, lat, TIMEOUT, TIMEOUT + 2);
    end
    tests++;
    if (rd !== 32'h0 || to !== 1'b1 || !bp) begin
      errs++;
      $display("FAIL timeout_response: rdata=%h to=%b clean=%b required 0/1/1", rd, to, bp);
    end
    xfer(1'b0, 10'h2FF, 32'h0, TIMEOUT - 1, 1'b0, 0, rd, to, lat, acc, su, bp, ac);
    tests++;
    if (acc !== TIMEOUT || rd !== dflt(10'h2FF) || to !== 1'b0) begin
      errs++;
      $display("FAIL pready_on_last_cycle: acc=%0d rdata=%h to=%b required %0d/%h/0",
               acc, rd, to, TIMEOUT, dflt(10'h2FF));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; bit to, su, bp; int lat, acc, ac;
    xfer(1'b0, 10'h3A4, 32'h0, 1, 1'b0, 5, rd, to, lat, acc, su, bp, ac);
    tests++;
    if (!bp) begin
      errs++;
      $display("FAIL backpressure_hold: stable=%b required 1", bp);
    end
    tests++;
    if (rd !== rmem[10'h3A4] || to !== 1'b0) begin
      errs++;
      $display("FAIL backpressure_data: rdata=%h to=%b required %h/0", rd, to, rmem[10'h3A4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d, er; bit to, su, bp, wr; int lat, acc, ac, prev_ac;
    prev_ac = -1;
    for (int i = 0; i < 16; i++) begin
      wr = (i % 2 == 0);
      d  = $urandom;
      er = wr ? 32'h0 : rmem[i / 2];
      xfer(wr, 10'(i / 2), d, 0, 1'b0, 0, rd, to, lat, acc, su, bp, ac);
      if (wr) rmem[i / 2] = d;
      tests++;
      if (rd !== er || to !== 1'b0 || lat !== 3 || !su) begin
        errs++;
        $display("FAIL b2b_xfer%0d: rdata=%h to=%b lat=%0d setup=%b required %h/0/3/1", i, rd, to, lat, su, er);
      end
      if (prev_ac >= 0) begin
        tests++;
        if (ac - prev_ac !== 4) begin
          errs++;
          $display("FAIL b2b_spacing%0d: %0d cycles required 4", i, ac - prev_ac);
        end
      end
      prev_ac = ac;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, er; bit to, su, bp, wr, stk, eto; int lat, acc, ac, w, rdl, ea;
    logic [9:0] a;
    for (int i = 0; i < 24; i++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 10'h100 + 10'($urandom_range(0, 15));
      d   = $urandom;
      stk = ($urandom_range(0, 9) == 0);
      w   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      rdl = $urandom_range(0, 2);
      eto = stk || (w >= TIMEOUT);
      ea  = eto ? TIMEOUT : w + 1;
      er  = (wr || eto) ? 32'h0 : (rmem.exists(int'(a)) ? rmem[int'(a)] : dflt(a));
      xfer(wr, a, d, w, stk, rdl, rd, to, lat, acc, su, bp, ac);
      if (wr && !eto) rmem[int'(a)] = d;
      tests++;
      if (rd !== er || to !== eto) begin
        errs++;
        $display("FAIL rand%0d_rsp: rdata=%h to=%b required %h/%b", i, rd, to, er, eto);
      end
      tests++;
      if (acc !== ea || lat !== ea + 2 || !su || !bp) begin
        errs++;
        $display("FAIL rand%0d_timing: acc=%0d lat=%0d setup=%b bp=%b required %0d/%0d/1/1",
                 i, acc, lat, su, bp, ea, ea + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, d; bit to, su, bp, seen; int lat, acc, ac;
    s_waits = 5; s_stuck = 1'b0;
    bif.rsp_ready = 1'b1;
    bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = 10'h055;
    while (!bif.req_ready) @(negedge clk);
    @(negedge clk);                 // SETUP
    bif.req_valid = 1'b0;
    @(negedge clk);                 // first wait cycle
    @(negedge clk);                 // second wait cycle
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({bif.psel, bif.penable, bif.rsp_valid, bif.req_ready} !== 4'b0) begin
      errs++;
      $display("FAIL reset_mid_access: sel=%b en=%b vld=%b rdy=%b required 0000",
               bif.psel, bif.penable, bif.rsp_valid, bif.req_ready);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bif.rsp_valid || bif.psel) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      errs++;
      $display("FAIL reset_mid_no_response: stray activity=%b required 0", seen);
    end
    d = $urandom;
    xfer(1'b1, 10'h055, d, 1, 1'b0, 0, rd, to, lat, acc, su, bp, ac);
    rmem[10'h055] = d;
    tests++;
    if (to !== 1'b0 || rd !== 32'h0 || lat !== 4 || !su) begin
      errs++;
      $display("FAIL reset_mid_write_after: to=%b rdata=%h lat=%0d setup=%b required 0/0/4/1", to, rd, lat, su);
    end
    xfer(1'b0, 10'h055, 32'h0, 0, 1'b0, 0, rd, to, lat, acc, su, bp, ac);
    tests++;
    if (rd !== d || to !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_readback: rdata=%h to=%b required %h/0", rd, to, d);
    end
  endtask

  initial begin
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.rsp_ready = 1'b1;
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
